// File: rtl/ptw_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ptw_responder_pkg
//  Description : Shared types for the PTW responder: FSM state encoding and
//                the PTE cache entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package ptw_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_BUS = 3'd1,
        ST_BUS_RD   = 3'd2,
        ST_RESP     = 3'd3,
        ST_COOL     = 3'd4
    } ptw_resp_state_t;

    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] data;
    } pte_entry_t;

    // Every PTE read is a full aligned word.
    localparam logic [3:0] c_wb_sel_all = 4'b1111;

    // PTEs are word aligned; the byte offset never takes part in matching.
    function automatic logic [29:0] pte_tag(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ptw_responder_pte_cache.sv
`default_nettype none
// ============================================================================
//  Module      : pte_cache
//  Description : Small fully-associative PTE cache. Combinational lookup,
//                single-word fill (matching entry, else lowest free entry,
//                else round-robin victim), global flush of valid bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module pte_cache
    import ptw_responder_pkg::*;
#(
    parameter int PTE_ENTRIES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] lookup_tag,
    output logic        lookup_hit,
    output logic [31:0] lookup_data,
    input  logic        fill_en,
    input  logic [29:0] fill_tag,
    input  logic [31:0] fill_data,
    input  logic        flush
);

    localparam int c_idx_w = (PTE_ENTRIES > 1) ? $clog2(PTE_ENTRIES) : 1;

    pte_entry_t         r_entries [PTE_ENTRIES];
    logic [c_idx_w-1:0] r_victim;

    logic               w_fill_match;
    logic [c_idx_w-1:0] w_match_idx;
    logic               w_has_free;
    logic [c_idx_w-1:0] w_free_idx;
    logic [c_idx_w-1:0] w_fill_idx;
    logic               w_evict;
    logic [c_idx_w-1:0] w_victim_next;

    // Associative lookup against all valid entries.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int i = 0; i < PTE_ENTRIES; i++) begin
            if (r_entries[i].valid && (r_entries[i].tag == lookup_tag)) begin
                lookup_hit  = 1'b1;
                lookup_data = r_entries[i].data;
            end
        end
    end

    // Fill slot selection; descending scan so the lowest index wins.
    always_comb begin
        w_fill_match = 1'b0;
        w_match_idx  = '0;
        w_has_free   = 1'b0;
        w_free_idx   = '0;
        for (int i = PTE_ENTRIES - 1; i >= 0; i--) begin
            if (r_entries[i].valid && (r_entries[i].tag == fill_tag)) begin
                w_fill_match = 1'b1;
                w_match_idx  = i[c_idx_w-1:0];
            end
            if (!r_entries[i].valid) begin
                w_has_free = 1'b1;
                w_free_idx = i[c_idx_w-1:0];
            end
        end
        w_evict       = !w_fill_match && !w_has_free;
        w_fill_idx    = w_fill_match ? w_match_idx :
                        (w_has_free  ? w_free_idx  : r_victim);
        w_victim_next = (r_victim == c_idx_w'(PTE_ENTRIES - 1)) ? '0 : r_victim + 1'b1;
    end

    // Entry storage: flush beats fill; victim pointer moves only on eviction.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PTE_ENTRIES; i++) begin
                r_entries[i] <= '0;
            end
            r_victim <= '0;
        end else if (flush) begin
            for (int i = 0; i < PTE_ENTRIES; i++) begin
                r_entries[i].valid <= 1'b0;
            end
        end else if (fill_en) begin
            r_entries[w_fill_idx] <= '{valid: 1'b1, tag: fill_tag, data: fill_data};
            if (w_evict) begin
                r_victim <= w_victim_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ptw_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ptw_responder
//  Description : Slave endpoint of the PTW read port. Serves hits from the
//                PTE cache in one cycle, turns misses into a single-word
//                Wishbone read on the bus shared with the DCache.
//  Revision    : 1.0 - initial release
// ============================================================================
module ptw_responder
    import ptw_responder_pkg::*;
#(
    parameter int PTE_ENTRIES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ptw_addr_i,
    input  logic        ptw_req_i,
    output logic [31:0] ptw_data_o,
    output logic        ptw_ack_o,
    input  logic        sfence_i,
    input  logic        bus_busy_i,
    output logic        ptw_bus_own_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    ptw_resp_state_t r_state;
    ptw_resp_state_t w_next_state;
    logic [29:0]     r_tag;
    logic            r_abort;
    logic            r_poison;
    logic [31:0]     r_data;
    logic            r_ack;
    logic            r_cyc;

    logic [29:0]     w_req_tag;
    logic            w_cache_hit;
    logic [31:0]     w_cache_data;
    logic            w_hit;
    logic            w_abort_now;
    logic            w_fill_en;
    logic            w_bus_own;
    logic            w_unused_addr_lsb;

    assign w_req_tag         = pte_tag(ptw_addr_i);
    assign w_unused_addr_lsb = ^ptw_addr_i[1:0];

    // A flush in the lookup cycle turns a hit into a miss.
    assign w_hit       = w_cache_hit && !sfence_i;
    // The arbiter dropped or redirected the request we are working on.
    assign w_abort_now = r_abort || !ptw_req_i || (w_req_tag != r_tag);
    // Fills landing with or after an sfence would resurrect stale PTEs.
    assign w_fill_en   = (r_state == ST_BUS_RD) && wb_ack_i && !r_poison && !sfence_i;

    pte_cache #(
        .PTE_ENTRIES (PTE_ENTRIES)
    ) u_pte_cache (
        .clk         (clk),
        .rst         (rst),
        .lookup_tag  (w_req_tag),
        .lookup_hit  (w_cache_hit),
        .lookup_data (w_cache_data),
        .fill_en     (w_fill_en),
        .fill_tag    (r_tag),
        .fill_data   (wb_dat_i),
        .flush       (sfence_i)
    );

    // Next-state and bus ownership; a free bus at miss time skips WAIT_BUS.
    always_comb begin
        w_next_state = r_state;
        w_bus_own    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ptw_req_i) begin
                    if (w_hit) begin
                        w_next_state = ST_RESP;
                    end else if (!bus_busy_i) begin
                        w_next_state = ST_BUS_RD;
                        w_bus_own    = 1'b1;
                    end else begin
                        w_next_state = ST_WAIT_BUS;
                    end
                end
            end
            ST_WAIT_BUS: begin
                if (w_abort_now) begin
                    w_next_state = ST_IDLE;
                end else if (!bus_busy_i) begin
                    w_next_state = ST_BUS_RD;
                    w_bus_own    = 1'b1;
                end
            end
            ST_BUS_RD: begin
                w_bus_own = 1'b1;
                if (wb_ack_i) begin
                    w_next_state = w_abort_now ? ST_COOL : ST_RESP;
                end
            end
            ST_RESP: w_next_state = ST_COOL;
            ST_COOL: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State, request context and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_tag    <= '0;
            r_abort  <= 1'b0;
            r_poison <= 1'b0;
            r_data   <= '0;
            r_ack    <= 1'b0;
            r_cyc    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ack   <= (w_next_state == ST_RESP);
            r_cyc   <= (w_next_state == ST_BUS_RD);
            case (r_state)
                ST_IDLE: begin
                    if (ptw_req_i) begin
                        r_tag    <= w_req_tag;
                        r_abort  <= 1'b0;
                        r_poison <= 1'b0;
                        if (w_hit) begin
                            r_data <= w_cache_data;
                        end
                    end
                end
                ST_WAIT_BUS: begin
                    if (w_abort_now) begin
                        r_abort <= 1'b1;
                    end
                end
                ST_BUS_RD: begin
                    if (w_abort_now) begin
                        r_abort <= 1'b1;
                    end
                    if (sfence_i) begin
                        r_poison <= 1'b1;
                    end
                    if (wb_ack_i) begin
                        r_data <= wb_dat_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ptw_data_o    = r_data;
    assign ptw_ack_o     = r_ack;
    assign ptw_bus_own_o = w_bus_own;
    assign wb_cyc_o      = r_cyc;
    assign wb_stb_o      = r_cyc;
    assign wb_adr_o      = {r_tag, 2'b00};
    assign wb_sel_o      = c_wb_sel_all;
    assign wb_we_o       = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ptw_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ptw_responder
//  Description : Self-checking bench for ptw_responder: table of PTW
//                transactions against a Wishbone slave model, plus directed
//                sequences for back-to-back, WAIT_BUS abort and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ptw_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ptw_addr_i;
    logic        ptw_req_i;
    logic [31:0] ptw_data_o;
    logic        ptw_ack_o;
    logic        sfence_i;
    logic        bus_busy_i;
    logic        ptw_bus_own_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ptw_responder #(
        .PTE_ENTRIES (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ptw_addr_i    (ptw_addr_i),
        .ptw_req_i     (ptw_req_i),
        .ptw_data_o    (ptw_data_o),
        .ptw_ack_o     (ptw_ack_o),
        .sfence_i      (sfence_i),
        .bus_busy_i    (bus_busy_i),
        .ptw_bus_own_o (ptw_bus_own_o),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .wb_adr_o      (wb_adr_o),
        .wb_sel_o      (wb_sel_o),
        .wb_we_o       (wb_we_o),
        .wb_dat_i      (wb_dat_i),
        .wb_ack_i      (wb_ack_i)
    );

    // Memory contents seen by the Wishbone slave model.
    function automatic logic [31:0] pte_of(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h8000_1004) return 32'h2000_00CF;
        return w ^ 32'h1357_9BDF;
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] addr2;   // address after the arbiter switches master
        int          sw_n;    // cycle of the switch, -1 none
        int          busy;    // bus_busy_i high for cycles 0..busy-1
        int          lat;     // wb_ack_i this many cycles after cyc rises
        int          sf_n;    // cycle of sfence_i pulse, -1 none
        int          exp_lat; // cycles from request to ptw_ack_o
        int          exp_wb;  // Wishbone cycles expected
    } vec_t;

    vec_t vecs [27];

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] a2, input int sw,
                                input int b, input int l, input int sf, input int el, input int ew);
        vec_t v;
        v.addr = a; v.addr2 = a2; v.sw_n = sw; v.busy = b; v.lat = l;
        v.sf_n = sf; v.exp_lat = el; v.exp_wb = ew;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t        v;
        int          ack_n;
        logic [31:0] ack_data;
        int          wb_cnt;
        int          own_first;
        int          cyc_start;
        logic        prev_cyc;
        logic [31:0] fin_addr;
        int          exp_own;
        v = vecs[i];
        ack_n = -1; ack_data = '0; wb_cnt = 0; own_first = -1;
        cyc_start = -1000; prev_cyc = 1'b0;
        @(posedge clk); #1;
        ptw_req_i  = 1'b1;
        ptw_addr_i = v.addr;
        bus_busy_i = (v.busy > 0);
        sfence_i   = (v.sf_n == 0);
        wb_ack_i   = 1'b0;
        #1;
        if (ptw_bus_own_o) own_first = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (ptw_ack_o) begin
                ack_n    = n;
                ack_data = ptw_data_o;
                break;
            end
            if (wb_cyc_o && !prev_cyc) begin
                wb_cnt++;
                cyc_start = n;
            end
            prev_cyc = wb_cyc_o;
            if (v.sw_n >= 0 && n >= v.sw_n) ptw_addr_i = v.addr2;
            bus_busy_i = (n < v.busy);
            sfence_i   = (n == v.sf_n);
            wb_ack_i   = wb_cyc_o && ((n - cyc_start) == v.lat);
            wb_dat_i   = pte_of(wb_adr_o);
            #1;
            if (ptw_bus_own_o && own_first < 0) own_first = n;
        end
        ptw_req_i = 1'b0; bus_busy_i = 1'b0; sfence_i = 1'b0; wb_ack_i = 1'b0;
        fin_addr = (v.sw_n >= 0) ? v.addr2 : v.addr;
        exp_own  = (v.exp_wb == 0) ? -1 : v.busy;
        chk($sformatf("v%0d_ack_latency", i), ack_n, v.exp_lat);
        chk($sformatf("v%0d_ack_data", i), ack_data, pte_of(fin_addr));
        chk($sformatf("v%0d_wb_cycles", i), wb_cnt, v.exp_wb);
        chk($sformatf("v%0d_own_first", i), own_first, exp_own);
        @(posedge clk); #1;
        chk($sformatf("v%0d_ack_single", i), {31'd0, ptw_ack_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [7:0] mask;
        logic       saw;

        vecs[0]  = mk(32'h8000_1004, 32'h0, -1, 0, 3, -1, 5, 1); // cold miss
        vecs[1]  = mk(32'h8000_1004, 32'h0, -1, 0, 3, -1, 1, 0); // hit
        vecs[2]  = mk(32'h8000_1007, 32'h0, -1, 0, 3, -1, 1, 0); // byte offset ignored
        vecs[3]  = mk(32'h8000_1100, 32'h0, -1, 4, 1, -1, 7, 1); // bus busy 4 cycles
        vecs[4]  = mk(32'h8000_1200, 32'h0, -1, 0, 0, -1, 2, 1); // zero-wait slave
        vecs[5]  = mk(32'h8000_1300, 32'h8000_2000, 2, 0, 2, -1, 9, 2); // switch in BUS_RD
        vecs[6]  = mk(32'h8000_1300, 32'h0, -1, 0, 1, -1, 1, 0); // aborted line filled
        vecs[7]  = mk(32'h8000_2000, 32'h0, -1, 0, 1, -1, 1, 0);
        vecs[8]  = mk(32'h8000_3000, 32'h0, -1, 0, 2, 2, 4, 1);  // sfence in BUS_RD
        vecs[9]  = mk(32'h8000_3000, 32'h0, -1, 0, 1, -1, 3, 1); // poisoned: misses
        vecs[10] = mk(32'h8000_1300, 32'h0, -1, 0, 1, -1, 3, 1); // flushed
        vecs[11] = mk(32'h8000_3400, 32'h0, -1, 0, 1, 2, 3, 1);  // sfence with wb_ack
        vecs[12] = mk(32'h8000_3400, 32'h0, -1, 0, 1, -1, 3, 1);
        vecs[13] = mk(32'h8000_3400, 32'h0, -1, 0, 1, 0, 3, 1);  // sfence in lookup
        vecs[14] = mk(32'h8000_3400, 32'h0, -1, 0, 1, -1, 1, 0);
        vecs[15] = mk(32'h8000_3000, 32'h0, -1, 0, 1, -1, 3, 1);
        vecs[16] = mk(32'h8000_4000, 32'h0, -1, 0, 1, -1, 3, 1); // after WAIT_BUS abort
        vecs[17] = mk(32'h9000_0000, 32'h0, -1, 0, 0, -1, 2, 1); // eviction set
        vecs[18] = mk(32'h9000_0010, 32'h0, -1, 0, 0, -1, 2, 1);
        vecs[19] = mk(32'h9000_0020, 32'h0, -1, 0, 0, -1, 2, 1);
        vecs[20] = mk(32'h9000_0030, 32'h0, -1, 0, 0, -1, 2, 1);
        vecs[21] = mk(32'h9000_0040, 32'h0, -1, 0, 0, -1, 2, 1); // evicts first
        vecs[22] = mk(32'h9000_0010, 32'h0, -1, 0, 0, -1, 1, 0);
        vecs[23] = mk(32'h9000_0020, 32'h0, -1, 0, 0, -1, 1, 0);
        vecs[24] = mk(32'h9000_0030, 32'h0, -1, 0, 0, -1, 1, 0);
        vecs[25] = mk(32'h9000_0040, 32'h0, -1, 0, 0, -1, 1, 0);
        vecs[26] = mk(32'h9000_0000, 32'h0, -1, 0, 0, -1, 2, 1); // victim misses again

        rst = 1'b1; ptw_addr_i = '0; ptw_req_i = 1'b0; sfence_i = 1'b0;
        bus_busy_i = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_ack",  {31'd0, ptw_ack_o}, 32'd0);
        chk("reset_data", ptw_data_o, 32'd0);
        chk("reset_cyc",  {31'd0, wb_cyc_o}, 32'd0);
        chk("reset_stb",  {31'd0, wb_stb_o}, 32'd0);
        chk("reset_adr",  wb_adr_o, 32'd0);
        chk("reset_own",  {31'd0, ptw_bus_own_o}, 32'd0);
        chk("const_sel",  {28'd0, wb_sel_o}, 32'hF);
        chk("const_we",   {31'd0, wb_we_o}, 32'd0);

        for (int i = 0; i <= 15; i++) run_vec(i);

        // Held request on a cached PTE: accepted again two cycles after each ack.
        @(posedge clk); #1;
        ptw_req_i = 1'b1; ptw_addr_i = 32'h8000_3400; mask = '0;
        for (int n = 1; n <= 7; n++) begin
            @(posedge clk); #1;
            mask[n] = ptw_ack_o;
            if (n == 1) chk("b2b_data", ptw_data_o, pte_of(32'h8000_3400));
        end
        ptw_req_i = 1'b0;
        chk("b2b_ack_pattern", {24'd0, mask}, 32'h0000_0092);
        @(posedge clk); #1;

        // Request withdrawn while waiting for the bus: no bus cycle, no fill.
        @(posedge clk); #1;
        ptw_req_i = 1'b1; ptw_addr_i = 32'h8000_4000; bus_busy_i = 1'b1;
        #1;
        saw = ptw_bus_own_o || wb_cyc_o;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            if (wb_cyc_o || ptw_ack_o) saw = 1'b1;
            bus_busy_i = (n <= 3);
            ptw_req_i  = (n < 2);
            #1;
            if (ptw_bus_own_o) saw = 1'b1;
        end
        bus_busy_i = 1'b0;
        chk("wait_abort_no_bus", {31'd0, saw}, 32'd0);
        run_vec(16);

        // Reset during a bus cycle, followed by a late wb_ack_i.
        @(posedge clk); #1;
        ptw_req_i = 1'b1; ptw_addr_i = 32'h9000_0000;
        @(posedge clk); #1;
        chk("rst_cyc_started", {31'd0, wb_cyc_o}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ptw_req_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
        #1;
        chk("rst_cyc_dropped", {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_stb_dropped", {31'd0, wb_stb_o}, 32'd0);
        chk("rst_own_dropped", {31'd0, ptw_bus_own_o}, 32'd0);
        chk("rst_adr_cleared", wb_adr_o, 32'd0);
        @(posedge clk); #1;
        wb_ack_i = 1'b0;
        chk("late_ack_no_ptw_ack", {31'd0, ptw_ack_o}, 32'd0);
        chk("late_ack_no_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("late_ack_data_held", ptw_data_o, 32'd0);

        for (int i = 17; i <= 26; i++) run_vec(i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ptw_responder.md
# ptw_responder

Slave-side endpoint of the PTW read port: services the single req/addr/data/ack stream produced by the IMMU/DMMU PTW arbiter. Hits in a small fully-associative PTE cache are answered directly; misses become a single-word Wishbone read on the memory bus shared with the DCache. It sits inside the DCache subsystem, between the arbiter output and the DCache bus mux.

## Interface
- PTE_ENTRIES, 4, PTE cache entries; power of two, 1..8.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ptw_addr_i  in  32  physical PTE address; bits [1:0] ignored
- ptw_req_i  in  1  level request, held until ack
- ptw_data_o  out  32  PTE word, valid only while ptw_ack_o=1
- ptw_ack_o  out  1  one-cycle completion pulse, always registered
- sfence_i  in  1  one-cycle pulse, invalidate all PTE cache entries
- bus_busy_i  in  1  DCache owns the memory bus this cycle
- ptw_bus_own_o  out  1  responder owns the bus (DCache must not start a cycle)
- wb_cyc_o, wb_stb_o  out  1 each  Wishbone cycle/strobe
- wb_adr_o  out  32  {addr[31:2], 2'b00}
- wb_sel_o  out  4  constant 4'b1111
- wb_we_o  out  1  constant 0
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  read ack

## Operation
- States: IDLE, WAIT_BUS, BUS_RD, RESP, COOL.
- IDLE: on ptw_req_i, latch tag=addr[31:2] and lookup. Hit -> latch entry data, go RESP. Miss -> WAIT_BUS.
- WAIT_BUS: when bus_busy_i=0, assert ptw_bus_own_o, go BUS_RD. ptw_bus_own_o stays 1 through BUS_RD.
- BUS_RD: cyc=stb=1, adr from latched tag. On wb_ack_i: register wb_dat_i, fill cache (unless poisoned), go RESP (or COOL if aborted).
- RESP: ptw_ack_o=1, ptw_data_o=latched data; go COOL.
- COOL: ptw_req_i ignored for one cycle; go IDLE.
- Abort: in WAIT_BUS/BUS_RD, if ptw_req_i=0 or ptw_addr_i[31:2] != latched tag (arbiter switched master), set abort flag. WAIT_BUS+abort -> IDLE immediately, no bus cycle. BUS_RD+abort -> bus cycle completes, line filled, no ack, go COOL.
- Fill: first invalid entry (lowest index), else round-robin victim pointer; pointer advances on each fill that evicts.
- sfence_i: clears all valid bits at the next edge; a fill in flight when sfence_i is seen (BUS_RD or same cycle as wb_ack_i) is poisoned, not written; its data is still acked if not aborted.
- sfence_i in IDLE with req: lookup uses pre-flush state counting as miss (flush wins over hit).
- Duplicate tags never created: fill checks hit first and overwrites the matching entry.

## Timing
- Reset values: state=IDLE, all valid=0, victim pointer=0, ptw_ack_o=0, ptw_data_o=0, wb_cyc_o=wb_stb_o=0, wb_adr_o=0, ptw_bus_own_o=0.
- Hit: req sampled cycle T -> ack at T+1. Never 0-cycle.
- Miss, bus free: req at T, cyc/stb rise T+1, wb_ack_i at T+1+k -> ptw_ack_o at T+2+k.
- Back-to-back: next request earliest accepted two cycles after ack (RESP, COOL).
- ptw_data_o held at last value when ack=0; verification checks data only with ack.
- rst mid-bus-cycle: cyc/stb drop next edge; late wb_ack_i ignored in IDLE.

## Structure
- Shared package: state enum ptw_resp_state_t, PTE cache entry struct {valid, tag[29:0], data[31:0]}.
- Sub-module pte_cache (lookup, fill, flush, victim pointer); FSM and Wishbone in ptw_responder.

## Test plan
- Cold miss addr 0x8000_1004, wb ack after 3 cycles data 0x2000_00CF -> ack 5 cycles after req, data 0x2000_00CF, exactly one Wishbone cycle.
- Repeat same addr -> ack T+1, no wb_cyc_o.
- bus_busy_i=1 for 4 cycles during miss -> no cyc until busy low; ptw_bus_own_o asserted first free cycle.
- During BUS_RD, addr switches to 0x8000_2000 -> no ack for old; bus completes; new request served after COOL; old addr later hits.
- Fill 5 distinct addrs with PTE_ENTRIES=4 -> first addr misses again, others hit.
- sfence_i during BUS_RD for 0x8000_3000 -> ack delivered with bus data; repeated request misses again.
